dmem_responder: RTL

Data-memory responder serving the load/store requests issued by the core datapath. It receives one request at a time over a valid/ready channel, inserts a configurable number of wait states, and commits byte-lane writes or returns read data. Results come back on a valid/ready response channel. It sits between the core's memory port and the word-organised data store.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data store behind a valid/ready load/store port with configurable wait states.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses beyond the store with resp_err=1.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, next;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        cur_we;
    logic        cur_oor;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic [AW-1:0] idx;
    logic        unused_addr_bits;

    // With zero wait states the commit happens on the accept edge, so the live request is used there.
    assign accept    = (state == S_IDLE) && req_valid;
    assign cur_we    = (state == S_IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == S_IDLE) ? req_be    : lat_be;
    assign idx       = cur_addr[AW+1:2];
    assign commit    = reset && (state != S_RESP) && (next == S_RESP);
    assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[31:AW+2]};

`ifdef DMEM_RANGE_CHECK_EN
    assign cur_oor = |(cur_addr >> (AW + 2));
`else
    assign cur_oor = 1'b0;
`endif

    // Next-state selection: accept in IDLE, count down wait states, hold RESP until taken.
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (req_valid) next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) next = S_RESP;
            S_RESP:  if (resp_ready) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state      <= next;
            req_ready  <= (next == S_IDLE);
            resp_valid <= (next == S_RESP);
        end
    end

    // Latch the accepted request and run the wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            cnt       <= 4'(WAIT_CYCLES);
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response data and error are captured once, on entry into RESP, and then held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_rdata <= (cur_we || cur_oor) ? '0 : mem[idx];
            resp_err   <= cur_oor;
        end
    end

    // Byte-lane store commit; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_oor)
            for (int i = 0; i < 4; i++)
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
endmodule
